hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core. It drives the 2-bit selects of the two EX-stage three-input operand multiplexers (register file / writeback result / MEM-stage ALU result). It also generates stall and flush controls for the F/D/E/M/W pipeline registers. The block keeps its own shadow pipeline of register-use information (ID→EX→MEM→WB), so it only needs decode-stage fields, the EX branch outcome and the data-memory ready handshake.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: decode-stage fields and pipeline status in,
// operand forward selects and pipeline stall/flush controls out.
interface hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       id_mem_access;
  logic       ex_pc_src;
  logic       mem_ready;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       stall_w;
  logic       flush_d;
  logic       flush_e;
  logic       mem_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load,
           id_mem_access, ex_pc_src, mem_ready,
    input  fwd_a_sel, fwd_b_sel, stall_f, stall_d, stall_e, stall_m, stall_w,
           flush_d, flush_e, mem_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load,
           id_mem_access, ex_pc_src, mem_ready,
    output fwd_a_sel, fwd_b_sel, stall_f, stall_d, stall_e, stall_m, stall_w,
           flush_d, flush_e, mem_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: shadow ID->EX->MEM->WB register-use
// tracking, EX operand forwarding, load-use / branch / memory-wait controls.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
    logic       mem_access;
  } ex_stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_access;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } wb_stage_t;

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q;
  wb_stage_t  wb_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic       mem_err_q;

  logic mem_wait, load_use, ex_wr, mem_wr, wb_wr;

  // Producer qualification: x0 is never a real destination
  always_comb begin
    ex_wr    = ex_q.valid  & ex_q.reg_write  & (ex_q.rd  != 5'd0);
    mem_wr   = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0);
    wb_wr    = wb_q.valid  & wb_q.reg_write  & (wb_q.rd  != 5'd0);
    mem_wait = mem_q.valid & mem_q.mem_access & ~hz.mem_ready;
    load_use = hz.id_valid & ex_q.is_load & ex_wr &
               ((ex_q.rd == hz.id_rs1) | (ex_q.rd == hz.id_rs2));
  end

  // Operand forwarding: MEM holds the newer value, so it wins over WB
  always_comb begin
    hz.fwd_a_sel = SEL_REG;
    hz.fwd_b_sel = SEL_REG;
    if (mem_wr && mem_q.rd == ex_q.rs1)     hz.fwd_a_sel = SEL_MEM;
    else if (wb_wr && wb_q.rd == ex_q.rs1)  hz.fwd_a_sel = SEL_WB;
    if (mem_wr && mem_q.rd == ex_q.rs2)     hz.fwd_b_sel = SEL_MEM;
    else if (wb_wr && wb_q.rd == ex_q.rs2)  hz.fwd_b_sel = SEL_WB;
  end

  // Stall/flush priority: memory wait, then branch, then load-use
  always_comb begin
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.stall_e = 1'b0;
    hz.stall_m = 1'b0;
    hz.stall_w = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    if (mem_wait) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.stall_e = 1'b1;
      hz.stall_m = 1'b1;
      hz.stall_w = 1'b1;
    end else if (hz.ex_pc_src) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
    end else if (load_use) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.flush_e = 1'b1;
    end
  end

  always_comb begin
    ex_d = '0;
    if (!hz.flush_e) begin
      ex_d.valid      = hz.id_valid;
      ex_d.rs1        = hz.id_rs1;
      ex_d.rs2        = hz.id_rs2;
      ex_d.rd         = hz.id_rd;
      ex_d.reg_write  = hz.id_reg_write;
      ex_d.is_load    = hz.id_is_load;
      ex_d.mem_access = hz.id_mem_access;
    end
    cnt_inc = (cnt_q == CW'(MEM_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
  end

  // Shadow pipeline advances unless the MEM access is still pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_wait) begin
      ex_q  <= ex_d;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                 mem_access: ex_q.mem_access};
      wb_q  <= '{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
    end
  end

  // Flag becomes visible in the wait cycle after the count reaches the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else if (mem_wait) begin
      cnt_q <= cnt_inc;
      if (cnt_inc == CW'(MEM_TIMEOUT)) mem_err_q <= 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign hz.mem_err = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MEM_TIMEOUT=3.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_if hz ();
  hazard_ctrl #(.MEM_TIMEOUT(3)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  always #5 clk = ~clk;

  // {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e}
  logic [6:0] ctrl;
  assign ctrl = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.stall_w,
                 hz.flush_d, hz.flush_e};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100001;
  localparam logic [6:0] C_BR   = 7'b0000011;
  localparam logic [6:0] C_WAIT = 7'b1111100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic ld,
                        input logic ma);
    hz.id_valid      = v;
    hz.id_rs1        = rs1;
    hz.id_rs2        = rs2;
    hz.id_rd         = rd;
    hz.id_reg_write  = rw;
    hz.id_is_load    = ld;
    hz.id_mem_access = ma;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    hz.ex_pc_src = 1'b0;
    hz.mem_ready = 1'b1;
    nop();
    #3;
    check("rst_ctrl", 32'(ctrl), 32'(C_NONE));
    check("rst_fwd", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'd0);
    check("rst_err", 32'(hz.mem_err), 32'd0);
    tick();
    rst_n = 1'b1;

    // add x5,x1,x2 ; sub x6,x5,x1
    tick();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
    set_id(1, 5'd5, 5'd1, 5'd6, 1, 0, 0);
    check("b2b_ctrl", 32'(ctrl), 32'(C_NONE));
    tick(); nop();
    check("b2b_fwd_a", 32'(hz.fwd_a_sel), 32'd2);
    check("b2b_fwd_b", 32'(hz.fwd_b_sel), 32'd0);

    // add x5 ; add x9,x3,x4 ; sub x6,x5,x1
    tick();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
    set_id(1, 5'd3, 5'd4, 5'd9, 1, 0, 0); tick();
    set_id(1, 5'd5, 5'd1, 5'd6, 1, 0, 0); tick();
    nop();
    check("gap_fwd_a", 32'(hz.fwd_a_sel), 32'd1);
    check("gap_fwd_b", 32'(hz.fwd_b_sel), 32'd0);

    // x5 written in WB and MEM, consumer reads x5 twice
    tick();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
    set_id(1, 5'd3, 5'd4, 5'd5, 1, 0, 0); tick();
    set_id(1, 5'd5, 5'd5, 5'd10, 1, 0, 0); tick();
    nop();
    check("both_fwd", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'b1010);

    // rd=x0 everywhere, consumer of x0
    tick();
    set_id(1, 5'd1, 5'd2, 5'd0, 1, 0, 0); tick();
    set_id(1, 5'd3, 5'd4, 5'd0, 1, 0, 0); tick();
    set_id(1, 5'd0, 5'd0, 5'd11, 1, 0, 0); tick();
    nop();
    check("x0_fwd", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'd0);

    // lw x0 followed by a reader of x0: no stall
    tick();
    set_id(1, 5'd2, 5'd0, 5'd0, 1, 1, 1); tick();
    set_id(1, 5'd0, 5'd0, 5'd12, 1, 0, 0);
    check("x0_load_ctrl", 32'(ctrl), 32'(C_NONE));

    // lw x7 ; add x8,x7,x7
    tick(); nop(); tick(); tick();
    set_id(1, 5'd2, 5'd0, 5'd7, 1, 1, 1); tick();
    set_id(1, 5'd7, 5'd7, 5'd8, 1, 0, 0);
    check("lu_stall", 32'(ctrl), 32'(C_LU));
    tick();
    check("lu_after", 32'(ctrl), 32'(C_NONE));
    check("lu_bubble_fwd", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'd0);
    tick(); nop();
    check("lu_fwd", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'b0101);

    // branch taken in the same cycle as a load-use
    tick(); tick(); tick();
    set_id(1, 5'd2, 5'd0, 5'd7, 1, 1, 1); tick();
    set_id(1, 5'd7, 5'd7, 5'd8, 1, 0, 0);
    hz.ex_pc_src = 1'b1; #1;
    check("br_lu_ctrl", 32'(ctrl), 32'(C_BR));
    tick();
    hz.ex_pc_src = 1'b0;
    nop();
    check("br_ex_bubble", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'd0);
    check("br_after", 32'(ctrl), 32'(C_NONE));

    // store waits in MEM for 5 cycles with a pending branch
    tick(); tick(); tick();
    set_id(1, 5'd2, 5'd3, 5'd0, 0, 0, 1); tick();
    nop(); tick();
    hz.mem_ready = 1'b0;
    hz.ex_pc_src = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wait_ctrl%0d", i), 32'(ctrl), 32'(C_WAIT));
      check($sformatf("wait_err%0d", i), 32'(hz.mem_err), (i >= 3) ? 32'd1 : 32'd0);
      tick();
    end
    hz.mem_ready = 1'b1; #1;
    check("wait_release", 32'(ctrl), 32'(C_BR));
    check("err_sticky", 32'(hz.mem_err), 32'd1);
    tick();
    hz.ex_pc_src = 1'b0; #1;
    check("err_sticky2", 32'(hz.mem_err), 32'd1);

    // asynchronous reset in the middle of a wait
    set_id(1, 5'd2, 5'd3, 5'd0, 0, 0, 1); tick();
    nop(); tick();
    hz.mem_ready = 1'b0; #1;
    check("rw_stall", 32'(ctrl), 32'(C_WAIT));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_ctrl", 32'(ctrl), 32'(C_NONE));
    check("rw_fwd", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'd0);
    check("rw_err", 32'(hz.mem_err), 32'd0);
    #3;
    rst_n = 1'b1;
    hz.mem_ready = 1'b1;
    tick();
    check("post_rst_ctrl", 32'(ctrl), 32'(C_NONE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
